// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command generator that feeds the srff set/reset flip-flop.
//
// Each raw request level is put through a two-flop synchronizer and a
// debouncer. A debounced rising edge marks that request as pending. The
// FSM turns each pending request into exactly one single-cycle pulse on
// s or r, and it never drives both in the same cycle. Between
// back-to-back pulses it inserts GAP_CYCLES idle cycles. When both
// requests are pending it serves the CLR_PRIORITY side first.
//
// Handshake: there is no ready/valid. A request is a level. Its debounced
// 0->1 edge is latched as pending and is held until the pulse is issued.
// Further edges that arrive while a request is pending merge into it.
//
// Parameters:
//   DB_CYCLES    (>=1) stable synchronized cycles needed to accept a level
//   GAP_CYCLES   (>=0) idle cycles between consecutive pulses
//   CLR_PRIORITY 1: r wins a tie, 0: s wins a tie
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   set_in, clr_in     raw asynchronous request levels
//   s, r               registered one-cycle command pulses
//   busy               registered; high whenever the FSM is not IDLE
//   conflict           registered; pulses with s/r when both requests were pending
// Debug: the FSM state is held in state_q (type state_e).
module sr_cmd_gen #(
  parameter int DB_CYCLES    = 4,
  parameter int GAP_CYCLES   = 2,
  parameter bit CLR_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_e;

  // Channel index 0 is the set request and index 1 is the clear request.
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]          db_level_q, db_level_d;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          rise;
  logic [1:0]          pend_q, pend_d, served;
  state_e              state_q, state_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                s_q, s_d, r_q, r_d, busy_q, busy_d, conf_q, conf_d;
  logic                issue, pick_clr;

  // Synchronizer and debounce. A level is accepted on the edge where the
  // mismatch count would reach DB_CYCLES. Any agreeing cycle resets the count.
  always_comb begin
    sync1_d    = {clr_in, set_in};
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    rise       = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_level_d[i] = sync2_q[i];
          rise[i]       = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // FSM next state and pulse selection.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else if (|pend_q) begin
          issue = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (|pend_q) begin
            issue   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // When both requests are pending the priority side is served. The
    // other side stays pending and is picked up after the gap.
    pick_clr = (&pend_q) ? CLR_PRIORITY : pend_q[1];
    s_d      = issue & ~pick_clr;
    r_d      = issue & pick_clr;
    conf_d   = issue & (&pend_q);
    served   = {r_d, s_d};
    pend_d   = (pend_q & ~served) | rise;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_level_q <= '0;
      db_cnt_q   <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conf_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conf_q     <= conf_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conf_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen (DB_CYCLES=4, GAP_CYCLES=2, CLR_PRIORITY=1).
// Inputs change on the falling edge. Outputs are checked 1 ns after each
// rising edge. "Edge e" counts the rising edges after an input change.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s, r, busy, conflict;
  int   n_vec = 0;
  int   n_err = 0;

  sr_cmd_gen #(.DB_CYCLES(4), .GAP_CYCLES(2), .CLR_PRIORITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .set_in(set_in), .clr_in(clr_in),
    .s(s), .r(r), .busy(busy), .conflict(conflict)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Checker.
  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input logic es, input logic er, input logic eb, input logic ec);
    chk("s", s, es);
    chk("r", r, er);
    chk("busy", busy, eb);
    chk("conflict", conflict, ec);
    chk("s_and_r", s & r, 1'b0);
  endtask

  // Driver: advance one rising edge, then check.
  task automatic step(input logic es, input logic er, input logic eb, input logic ec);
    @(posedge clk);
    #1;
    check_all(es, er, eb, ec);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset held with both requests high, then release with inputs low.
    set_in = 1'b1;
    clr_in = 1'b1;
    #1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    quiet(3);
    @(negedge clk);
    set_in = 1'b0;
    clr_in = 1'b0;
    rst_n  = 1'b1;
    quiet(20);

    // 2: set held for 12 cycles. s fires after edge 7, followed by a 2-cycle gap.
    @(negedge clk);
    set_in = 1'b1;
    for (int e = 1; e <= 12; e++)
      step(e == 7, 1'b0, (e >= 7) && (e <= 9), 1'b0);
    @(negedge clk);
    set_in = 1'b0;
    quiet(10);

    // 3: a 3-cycle glitch is filtered.
    @(negedge clk);
    set_in = 1'b1;
    quiet(3);
    @(negedge clk);
    set_in = 1'b0;
    quiet(20);

    // 4: simultaneous requests. r wins with conflict; s follows after the gap.
    @(negedge clk);
    set_in = 1'b1;
    clr_in = 1'b1;
    for (int e = 1; e <= 16; e++)
      step(e == 10, e == 7, (e >= 7) && (e <= 12), e == 7);
    @(negedge clk);
    set_in = 1'b0;
    clr_in = 1'b0;
    quiet(10);

    // 5: clr raised one cycle after s fires. Its debounce latency dominates,
    // so r fires after edge 15.
    @(negedge clk);
    set_in = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      if (e == 9) begin
        @(negedge clk);
        clr_in = 1'b1;
      end
      step(e == 7, e == 15, ((e >= 7) && (e <= 9)) || ((e >= 15) && (e <= 17)), 1'b0);
    end
    @(negedge clk);
    set_in = 1'b0;
    clr_in = 1'b0;
    quiet(10);

    // 6: reset during the gap that follows a conflict, with set held high.
    @(negedge clk);
    set_in = 1'b1;
    clr_in = 1'b1;
    for (int e = 1; e <= 8; e++)
      step(1'b0, e == 7, e >= 7, e == 7);
    @(negedge clk);
    rst_n  = 1'b0;
    clr_in = 1'b0;
    #1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    quiet(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++)
      step(e == 7, 1'b0, (e >= 7) && (e <= 9), 1'b0);

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command stage for the `srff` set/reset flip-flop. It takes two raw, asynchronous request levels (`set_in`, `clr_in`), synchronizes and debounces them, and turns each debounced rising edge into a single-cycle `s` or `r` pulse. It also resolves simultaneous requests by priority and enforces a minimum idle gap between pulses. The flip-flop therefore never sees `s` and `r` high together and never sees multi-cycle or glitch commands.

## Interface
- `DB_CYCLES`, default 4: number of consecutive stable synchronized cycles before a level is accepted. Legal range is ≥1.
- `GAP_CYCLES`, default 2: exact number of idle cycles inserted between back-to-back pulses. Legal range is ≥0.
- `CLR_PRIORITY`, default 1: when 1, `r` wins a simultaneous request; when 0, `s` wins.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `set_in`  input  1  raw set request level, asynchronous to `clk`.
- `clr_in`  input  1  raw clear request level, asynchronous to `clk`.
- `s`  output  1  registered one-cycle set pulse to `srff.s`.
- `r`  output  1  registered one-cycle reset pulse to `srff.r`.
- `busy`  output  1  registered; high when FSM is not IDLE.
- `conflict`  output  1  registered one-cycle flag: both requests were pending when a pulse was selected.

## Operation
- **Synchronizer:** per input, 2 flops, reset 0.
- **Debounce:** per input, keep `db_level` (reset 0) and a counter of width clog2(DB_CYCLES+1) (reset 0).
  - If the synchronized value equals `db_level`, the counter clears.
  - Otherwise the counter increments. On the edge where it would reach DB_CYCLES, `db_level` takes the synchronized value and the counter clears.
- **Pending flags** `set_pend`, `clr_pend` (reset 0):
  - Set on the same edge that `db_level` goes 0→1.
  - A further edge while already pending merges; no second pulse results.
  - Falling edges are ignored.
  - A pending flag clears on the edge its pulse is issued.
- **FSM states:** IDLE, ISSUE, GAP. Reset state is IDLE.
  - IDLE: if any flag is pending, go to ISSUE. On that edge, drive `s` or `r` high for the selected request and clear its flag.
  - ISSUE: lasts exactly one cycle.
    - If GAP_CYCLES>0, go to GAP.
    - If GAP_CYCLES=0: when a flag is pending, stay in ISSUE and issue the next pulse; otherwise go to IDLE.
  - GAP: `s`=`r`=0 for exactly GAP_CYCLES cycles, counted by a gap counter that resets to 0. Then go to ISSUE if a flag is pending, otherwise to IDLE.
- **Selection:** if only one flag is pending, issue it. If both are pending, issue the priority side (per `CLR_PRIORITY`); the other flag stays pending and `conflict` pulses high in the same cycle as the issued pulse.
- **Pulse invariant:** `s & r` is never 1. Each pulse is exactly 1 cycle wide.
- **Requests during ISSUE/GAP:** edges arriving in these states set their flags and are served after the gap.
- **Reset mid-operation:** `rst_n` low immediately clears all flops. `s`, `r`, `busy`, `conflict`, pending flags, counters and `db_level` go to 0, and the FSM returns to IDLE. An input held high through reset is re-debounced after release and yields one fresh pulse.

## Timing
- Reset values: `s`=0, `r`=0, `busy`=0, `conflict`=0.
- Latency, counting the first rising edge that samples the input high as edge 1 (input clean, FSM idle):
  - Sync output is valid after edge 2.
  - `db_level` and the pending flag are set on edge 2+DB_CYCLES.
  - The pulse is high during the cycle after edge 3+DB_CYCLES. With the default DB_CYCLES=4, that is edge 7.
- `busy` rises with the first pulse and falls on the edge the FSM re-enters IDLE.
- Back-to-back pulses are separated by exactly GAP_CYCLES low cycles on both `s` and `r`.
- A high or low glitch shorter than DB_CYCLES synchronized cycles produces no level change and no pulse.

## Test plan
All scenarios use DB_CYCLES=4 and GAP_CYCLES=2.
1. Hold `rst_n`=0 for 3 cycles with `set_in`=`clr_in`=1 → `s`=`r`=`busy`=`conflict`=0 throughout. Release with inputs at 0 → no pulse for 20 cycles.
2. Raise `set_in` and hold it high for 12 cycles → `s` is high only in the cycle after edge 7, `r` stays 0, and `busy` is high for the pulse cycle plus 2 gap cycles.
3. Pulse `set_in` high for 3 cycles, then low → `s` and `r` remain 0 for 20 cycles.
4. With `CLR_PRIORITY`=1, raise `set_in` and `clr_in` together → `r` and `conflict` are high after edge 7, `s`=`r`=0 after edges 8–9, and `s` is high after edge 10.
5. Raise `set_in`, and raise `clr_in` 1 cycle after `s` fires → `r` fires once, exactly 2 low cycles after `s` falls or at its own debounce latency, whichever is later. `s` and `r` never overlap.
6. With `set_in` held high, assert `rst_n`=0 during the GAP cycle that follows a queued conflict → all outputs drop to 0 immediately. After release, exactly one `s` pulse appears after edge 7 and no `r` pulse appears.
